// File: rtl/addsub_accum_seq_if.sv
// Bus between the scan accumulator and its surroundings: run control, memory read port, results.
// The master side is the requester plus the synchronous-read memory that supplies rd_data.
interface addsub_accum_seq_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [WIDTH-1:0]  ref_val;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              ovf;

    modport master (
        output start, ref_val, rd_data,
        input  rd_en, rd_addr, busy, done, result, ovf
    );

    modport slave (
        input  start, ref_val, rd_data,
        output rd_en, rd_addr, busy, done, result, ovf
    );
endinterface

// File: rtl/addsub_accum_seq.sv
// Scans DEPTH words from a synchronous-read memory, adding words >= ref_val and subtracting
// smaller ones into an accumulator, with sticky overflow and optional saturation.
module addsub_accum_seq #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int SATURATE = 0
) (
    input logic               clk,
    input logic               reset,
    addsub_accum_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              valid_reg;
    logic [WIDTH-1:0]  acc_reg;
    logic              ovf_reg;
    logic              done_reg;

    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic              add_sel;
    logic              step_ovf;
    logic [WIDTH-1:0]  wrap_next;
    logic [WIDTH-1:0]  acc_next;

    assign add_sel  = (bus.rd_data >= bus.ref_val);
    assign sum_ext  = {1'b0, acc_reg} + {1'b0, bus.rd_data};
    assign diff_ext = {1'b0, acc_reg} - {1'b0, bus.rd_data};

    // Bit WIDTH is the carry on add and the borrow on subtract.
    assign step_ovf  = add_sel ? sum_ext[WIDTH] : diff_ext[WIDTH];
    assign wrap_next = add_sel ? sum_ext[WIDTH-1:0] : diff_ext[WIDTH-1:0];

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                acc_next = wrap_next;
                if (step_ovf) begin
                    acc_next = add_sel ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                end
            end
        end else begin : g_wrap
            assign acc_next = wrap_next;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            // Memory data lags rd_en by one cycle; the valid flag tracks that lag.
            valid_reg <= (state_reg == RUN);
            if (valid_reg) begin
                acc_reg <= acc_next;
                ovf_reg <= ovf_reg | step_ovf;
            end

            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en   = (state_reg == RUN);
    assign bus.rd_addr = cnt_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = done_reg;
    assign bus.result  = acc_reg;
    assign bus.ovf     = ovf_reg;
endmodule

// File: tb/tb_addsub_accum_seq.sv
// Randomised and directed runs on wrap and saturating instances; expected results are queued at
// issue time and a negedge monitor checks the read trace, done timing and final values.
module tb_addsub_accum_seq;
    localparam int W = 8;
    localparam int D = 8;
    localparam int A = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    addsub_accum_seq_if #(.WIDTH(W), .ADDR_W(A)) b0 ();
    addsub_accum_seq_if #(.WIDTH(W), .ADDR_W(A)) b1 ();

    addsub_accum_seq #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .bus(b0.slave));
    addsub_accum_seq #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .bus(b1.slave));

    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (b0.rd_en) b0.rd_data <= mem[b0.rd_addr];
        if (b1.rd_en) b1.rd_data <= mem[b1.rd_addr];
    end

    typedef struct {
        int res0;
        bit ovf0;
        int res1;
        bit ovf1;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int starts[$];
    bit prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: signed integer accumulator folded back into [0, 2^W) after every word.
    function automatic void model(input int r, input bit sat, output int res, output bit o);
        int acc = 0;
        o = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (int'(mem[i]) >= r) acc += int'(mem[i]);
            else acc -= int'(mem[i]);
            if (acc > 255) begin
                o = 1'b1;
                acc = sat ? 255 : acc - 256;
            end else if (acc < 0) begin
                o = 1'b1;
                acc = sat ? 0 : acc + 256;
            end
        end
        res = acc;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            int k;
            if (b0.busy && !prev_busy) begin
                start_cyc = cyc;
                starts.push_back(cyc);
            end
            if (b0.busy) begin
                k = cyc - start_cyc + 1;
                chk("rd_en", int'(b0.rd_en), int'(k <= D));
                if (k <= D) chk("rd_addr", int'(b0.rd_addr), k - 1);
                chk("done_cycle", int'(b0.done), int'(k == D + 2));
                chk("busy_match", int'(b1.busy), 1);
            end
            if (b0.done) begin
                chk("sat_done_align", int'(b1.done), 1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("run %0d: wrap result=%0d ovf=%0d (exp %0d/%0d) sat result=%0d ovf=%0d (exp %0d/%0d)",
                             done_cnt, b0.result, b0.ovf, e.res0, e.ovf0, b1.result, b1.ovf, e.res1, e.ovf1);
                    chk("wrap_result", int'(b0.result), e.res0);
                    chk("wrap_ovf", int'(b0.ovf), int'(e.ovf0));
                    chk("sat_result", int'(b1.result), e.res1);
                    chk("sat_ovf", int'(b1.ovf), int'(e.ovf1));
                end
                done_cnt++;
            end
            prev_busy = b0.busy;
        end
    end

    task automatic set_inputs(input bit s, input logic [W-1:0] r);
        b0.start = s;  b1.start = s;
        b0.ref_val = r; b1.ref_val = r;
    endtask

    task automatic push_exp(input int r);
        exp_t e;
        model(r, 1'b0, e.res0, e.ovf0);
        model(r, 1'b1, e.res1, e.ovf1);
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    task automatic run(input logic [W-1:0] r);
        int target;
        target = done_cnt + 1;
        push_exp(int'(r));
        set_inputs(1'b1, r);
        @(posedge clk); #1;
        b0.start = 1'b0; b1.start = 1'b0;
        wait_done(target, 3 * D);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < D; i++) mem[i] = W'(i + 1);
    endtask

    initial begin
        set_inputs(1'b0, '0);
        fill_seq();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", int'(b0.rd_en), 0);
        chk("rst_rd_addr", int'(b0.rd_addr), 0);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_done", int'(b0.done), 0);
        chk("rst_result", int'(b0.result), 0);
        chk("rst_ovf", int'(b0.ovf), 0);
        @(posedge clk); #1;

        // Ascending words, ref 0: everything adds to 36.
        run(8'd0);

        // Alternating 10/2 against ref 5 and the equality case ref 10.
        for (int i = 0; i < D; i++) mem[i] = (i % 2 == 0) ? W'(10) : W'(2);
        run(8'd5);
        run(8'd10);

        // All-subtract underflow and all-add overflow.
        for (int i = 0; i < D; i++) mem[i] = W'(1);
        run(8'd5);
        for (int i = 0; i < D; i++) mem[i] = W'(200);
        run(8'd0);

        // Start held high: the DONE-cycle start is ignored, the second run starts from IDLE.
        begin
            int target;
            int ns;
            fill_seq();
            target = done_cnt + 2;
            ns = starts.size();
            push_exp(0);
            push_exp(0);
            set_inputs(1'b1, 8'd0);
            wait_done(target, 6 * D);
            b0.start = 1'b0; b1.start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("held_start_runs", starts.size() - ns, 2);
            if (starts.size() - ns == 2)
                chk("held_start_spacing", starts[ns + 1] - starts[ns], D + 3);
        end

        // Reset in cycle 4 of a run aborts with no done pulse.
        begin
            mem[0] = 8'd77;
            set_inputs(1'b1, 8'd0);
            @(posedge clk); #1;
            b0.start = 1'b0; b1.start = 1'b0;
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("abort_rd_en", int'(b0.rd_en), 0);
            chk("abort_busy", int'(b0.busy), 0);
            chk("abort_done", int'(b0.done), 0);
            chk("abort_result", int'(b0.result), 0);
            chk("abort_ovf", int'(b0.ovf), 0);
            chk("abort_sat_result", int'(b1.result), 0);
            @(posedge clk); #1;
            fill_seq();
            run(8'd0);
        end

        // Randomised memory contents and reference values.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < D; i++) mem[i] = W'($urandom_range(0, 255));
            run(W'($urandom_range(0, 255)));
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/addsub_accum_seq.md
Name: addsub_accum_seq

Overview:
Parametrised sequencing accumulator for the memory-scan datapath. On start it reads DEPTH words from an external synchronous-read memory. It compares each word against a reference operand, then adds the word to, or subtracts it from, a running accumulator. It replaces the discrete address-counter / register / comparator / add-sub-mux chain with one block and adds overflow detection and an optional saturation mode.

Parameters:
WIDTH, 8, data and accumulator width in bits.
DEPTH, 8, number of words scanned per run (>= 2).
ADDR_W, 3, address width; must satisfy 2^ADDR_W >= DEPTH.
SATURATE, 0, 0 = modulo-2^WIDTH wrap, 1 = clamp to 0 / 2^WIDTH-1.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  run request; sampled only in IDLE.
ref_val  in  WIDTH  unsigned compare operand; must be held stable while busy.
rd_en  out  1  memory read enable.
rd_addr  out  ADDR_W  memory read address.
rd_data  in  WIDTH  memory read data, valid one cycle after rd_en.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
result  out  WIDTH  accumulator value; stable from done until the next accepted start.
ovf  out  1  sticky overflow/underflow flag for the current run.

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE, rd_en 0, rd_addr 0, busy 0, done 0, result 0, ovf 0.
- Reset mid-run aborts the run immediately. No done pulse is produced and no partial result is kept.
- States: IDLE, RUN, DRAIN, DONE.
- Cycle numbering: edge 0 is the edge that samples start=1 in IDLE; cycle k is the cycle after edge k.
- IDLE -> RUN on start=1. At that edge: accumulator cleared to 0, ovf cleared, address counter cleared.
- RUN occupies cycles 1..DEPTH:
  - rd_en=1 (combinational on state).
  - rd_addr = k-1; the counter increments each edge.
  - When the counter is DEPTH-1, the next state is DRAIN.
  - The counter never reaches DEPTH and does not wrap during a run.
- DRAIN occupies cycle DEPTH+1: rd_en=0, and the last word is consumed.
- DONE occupies cycle DEPTH+2: done=1 for exactly one cycle, then the block returns to IDLE unconditionally.
- start is ignored in RUN, DRAIN and DONE. start asserted in the DONE cycle does not launch a run; it must be held or reasserted in IDLE.
- Read pipeline: a valid flag registers rd_en. In every cycle where the flag is set, rd_data is consumed at the closing edge. Words read in cycles 1..DEPTH are consumed at edges 2..DEPTH+1, in address order.
- Per-word operation (unsigned compare):
  - rd_data >= ref_val: acc <= acc + rd_data. Equality counts as add.
  - rd_data < ref_val: acc <= acc - rd_data.
- Width rules: compute at WIDTH+1 bits.
  - A carry-out on add, or a borrow on subtract, sets ovf. ovf stays set until the next accepted start or reset.
  - SATURATE=0: keep the low WIDTH bits.
  - SATURATE=1: add overflow clamps to 2^WIDTH-1; subtract underflow clamps to 0. Later words continue from the clamped value.
- result is the accumulator register. It is visible while busy but only defined as final in the DONE cycle and after.
- busy = (state != IDLE).
- Total latency from the start edge to the done pulse is DEPTH+2 cycles. Back-to-back runs are spaced at least DEPTH+3 cycles apart.

Test Plan:
1. Defaults, memory {1,2,...,8}, ref_val=0, start at edge 0 -> rd_addr 0..7 in cycles 1..8, done only in cycle 10, result=36 (0x24), ovf=0, busy high in cycles 1..10.
2. Memory {10,2,10,2,10,2,10,2}, ref_val=5 -> accumulator sequence 10,8,18,16,26,24,34,32. Final result=32, ovf=0. Repeat with ref_val=10: the equality case adds, giving 10,8,18,16,26,24,34,32.
3. Memory all 1, ref_val=5 -> every word subtracts. SATURATE=0: result=248 (0xF8), ovf=1 from the first word. SATURATE=1: result=0, ovf=1.
4. Memory all 200, ref_val=0 -> SATURATE=0: result=64 (1600 mod 256), ovf=1. SATURATE=1: result=255, ovf=1.
5. Hold start high continuously -> runs start at edge 0 and again at edge 11 (start in the DONE cycle is ignored; the next run starts from IDLE). ovf and the accumulator are cleared at each new start, and done pulses once per run.
6. Assert reset in cycle 4 of a run -> next cycle shows IDLE: rd_en=0, busy=0, done=0, result=0, ovf=0, with no done pulse. A subsequent start completes normally with the case-1 values.
